spi_slave: RTL
==============

// Module: spi_slave
// PURPOSE
//  SPI responder (target) with the same bus and config encoding as the team's SPI master: modes 0-3
//  and word length 32/16/8/4. Oversamples SCLK/CS/MOSI on GCLK, shifts received MOSI bits in and
//  drives MISO, MSB first. Hands each complete word to the host with a 1-cycle valid pulse, and takes
//  the next TX word through a load/holding-register handshake. Lives on the loopback/peripheral side.
// PARAMETERS
//  SYNC_STAGES  2  flops per input synchroniser (SCLK, CS, MOSI); must be >= 2
// PORTS
//  GCLK          in   1   system clock; the only clock. SCLK must be <= GCLK/8.
//  RST           in   1   asynchronous, active-high reset
//  spi_mode_i    in   2   {CPOL,CPHA}; captured at CS fall, held for the frame
//  word_len_i    in   2   0:32 1:16 2:8 3:4 bits; captured at CS fall
//  tx_data_i     in   32  next word to send, right-aligned; bits above the word length are ignored
//  tx_load_i     in   1   1-cycle strobe; writes tx_data_i into the holding register
//  tx_empty_o    out  1   1 = holding register is free (reset 1)
//  rx_data_o     out  32  last received word, right-aligned, upper bits 0 (reset 0)
//  rx_valid_o    out  1   1-cycle pulse when rx_data_o updates (reset 0)
//  busy_o        out  1   1 while the synchronised CS is active (reset 0)
//  underrun_o    out  1   1-cycle pulse: word started with an empty holding register (reset 0)
//  frame_err_o   out  1   1-cycle pulse: CS deasserted mid-word (reset 0)
//  SCLK_i        in   1   SPI clock
//  CS_i          in   1   chip select, active low
//  MOSI_i        in   1   master out
//  MISO_o        out  1   slave out; registered (reset 0)
//  MISO_oe_o     out  1   MISO output enable = CS active, synchronised (reset 0)
// BEHAVIOUR
//  - Every async input goes through SYNC_STAGES flops. Edges are detected on the synchronised copies.
//  - Sample edge: rising if CPOL==CPHA, falling otherwise. Shift edge is the opposite edge.
//  - FSM IDLE -> ACTIVE on the CS fall edge. On entry: latch mode and length; set bit_cnt=len-1;
//    load the shift register from the holding register (tx_empty_o<=1), or load 0 and pulse underrun_o
//    if the holding register is empty. CPHA=0: drive MISO_o = tx[len-1] on that same cycle.
//  - ACTIVE, sample edge: rx_shift <= {rx_shift, MOSI}. If bit_cnt==0: rx_data_o <= rx word masked
//    to len; rx_valid_o=1 for one cycle; bit_cnt <= len-1; reload the shift register (same empty rule
//    and underrun rule as above). Otherwise bit_cnt--.
//  - ACTIVE, shift edge: CPHA=1 drives the current bit. CPHA=0 drives the next bit. The CPHA=0 shift
//    edge that falls on a word boundary drives the reloaded word's MSB. A leading shift edge before
//    the first sample edge (CPHA=1) drives MSB.
//  - Latency: rx_valid_o asserts SYNC_STAGES+1 GCLK cycles after the final sample edge at the pin.
//    MISO_o updates SYNC_STAGES+1 cycles after the shift edge.
//  - CS rise -> IDLE. If bit_cnt != len-1 (partial word): pulse frame_err_o, discard the partial word,
//    do not pulse rx_valid_o. Any loaded shift-register content is lost. The holding register is kept.
//  - tx_load_i while the holding register is full overwrites it (last write wins).
//  - tx_load_i on the same cycle as a reload: the reload takes the old holding value, the new value
//    fills the holding register, and tx_empty_o stays 0.
//  - Back-to-back words inside one CS are supported with no gap. Mode and length stay fixed until
//    CS rises.
//  - SCLK edges while CS is inactive are ignored. CS fall and a sample edge in the same synchronised
//    cycle: CS is processed first, then the edge is honoured.
//  - RST asserted at any time: all state and outputs return to reset values immediately.
//    Incomplete words are lost.
// STRUCTURE
//  - Shared package/header spi_defs: mode encoding, word-length encoding with len_bits(code) -> 32/16/8/4,
//    IDLE/ACTIVE state constants. The master should share these constants.
//  - Sub-module spi_sync_edge: N-flop synchroniser plus rise/fall pulse, instantiated for SCLK, CS, MOSI
//    (MOSI needs no edge output).
// TESTING (bench drives the team's SPI master as the bus model, GCLK 100 MHz)
//  1 Mode 0, 32-bit, tx 0xA5A5_1234, master sends 0xDEAD_BEEF -> rx_data_o=0xDEADBEEF, 1 rx_valid
//    pulse, master miso_data_o=0xA5A51234
//  2 Modes 1,2,3 x lengths 16/8/4 with 0xC3C3 / 0x5A / 0x9 both ways -> exact match, upper rx bits 0,
//    MISO_oe_o tracks CS
//  3 Two 8-bit words in one CS with a tx_load between them -> 2 rx_valid pulses, second word sent
//    correctly, no underrun
//  4 No tx_load before CS fall -> underrun_o pulse, MISO shifts 0, RX still received
//  5 CS forced high after 5 of 8 bits -> frame_err_o pulse, no rx_valid, rx_data_o unchanged, next frame OK
//  6 RST pulsed mid-word -> outputs at reset values within 1 cycle; a following full frame is correct

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared SPI bus definitions: mode/word-length encodings, FSM states and length helpers.
// The SPI master imports the same package so both ends agree on the config encoding.
package spi_defs;

   typedef struct packed {
      logic cpol;
      logic cpha;
   } spi_mode_t;

   typedef enum logic [1:0] {
      LEN_32 = 2'd0,
      LEN_16 = 2'd1,
      LEN_8  = 2'd2,
      LEN_4  = 2'd3
   } word_len_e;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } spi_state_e;

   function automatic logic [5:0] len_bits(input logic [1:0] code);
      return 6'd32 >> code;
   endfunction

   function automatic logic [31:0] len_mask(input logic [1:0] code);
      return 32'hFFFF_FFFF >> (6'd32 - len_bits(code));
   endfunction

endpackage

// File: rtl/spi_slave_sync_edge.sv
// N-flop input synchroniser with single-cycle rise/fall pulses on the synchronised level.
// RESET_VAL should match the idle level of the line so reset release creates no edge.
module spi_sync_edge #(
   parameter int unsigned STAGES    = 2,
   parameter logic        RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync;
   logic              prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync <= {STAGES{RESET_VAL}};
         prev <= RESET_VAL;
      end else begin
         sync <= {sync[STAGES-2:0], din};
         prev <= sync[STAGES-1];
      end
   end

   assign dout = sync[STAGES-1];
   assign rise = dout & ~prev;
   assign fall = ~dout & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI target: oversampled SCLK/CS/MOSI, MSB-first shift in/out, modes 0-3, 32/16/8/4-bit words,
// TX holding register with load handshake, and per-word rx valid / underrun / frame error pulses.
import spi_defs::*;

module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        GCLK,
   input  logic        RST,
   input  logic [1:0]  spi_mode_i,
   input  logic [1:0]  word_len_i,
   input  logic [31:0] tx_data_i,
   input  logic        tx_load_i,
   output logic        tx_empty_o,
   output logic [31:0] rx_data_o,
   output logic        rx_valid_o,
   output logic        busy_o,
   output logic        underrun_o,
   output logic        frame_err_o,
   input  logic        SCLK_i,
   input  logic        CS_i,
   input  logic        MOSI_i,
   output logic        MISO_o,
   output logic        MISO_oe_o
);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic cs_level_unused, cs_rise, cs_fall;
   logic mosi_s, mosi_rise_unused, mosi_fall_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
      .clk(GCLK), .rst(RST), .din(SCLK_i),
      .dout(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
      .clk(GCLK), .rst(RST), .din(CS_i),
      .dout(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
   );

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_mosi_sync (
      .clk(GCLK), .rst(RST), .din(MOSI_i),
      .dout(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   spi_state_e  state;
   spi_mode_t   mode_q, mode_eff;
   word_len_e   len_q, len_eff;
   logic [4:0]  bit_cnt, cnt_eff, len_m1;
   logic [31:0] tx_word, tx_eff, rx_shift, rx_next, hold, reload_word;
   logic        hold_full;
   logic        entering, in_frame, sample_hit, shift_hit, word_done, reload;

   // The CS-fall cycle uses the incoming config/word directly so a coincident SCLK edge is honoured.
   always_comb begin
      entering    = (state == ST_IDLE) && cs_fall;
      mode_eff    = entering ? spi_mode_t'(spi_mode_i) : mode_q;
      len_eff     = entering ? word_len_e'(word_len_i) : len_q;
      len_m1      = 5'(len_bits(len_eff) - 6'd1);
      in_frame    = entering || ((state == ST_ACTIVE) && !cs_rise);
      sample_hit  = in_frame && ((mode_eff.cpol == mode_eff.cpha) ? sclk_rise : sclk_fall);
      shift_hit   = in_frame && ((mode_eff.cpol == mode_eff.cpha) ? sclk_fall : sclk_rise);
      cnt_eff     = entering ? len_m1 : bit_cnt;
      word_done   = sample_hit && (cnt_eff == 5'd0);
      reload      = entering || word_done;
      reload_word = hold_full ? hold : '0;
      tx_eff      = entering ? reload_word : tx_word;
      rx_next     = {rx_shift[30:0], mosi_s};
   end

   always_ff @(posedge GCLK or posedge RST) begin
      if (RST) begin
         state       <= ST_IDLE;
         mode_q      <= '0;
         len_q       <= LEN_32;
         bit_cnt     <= '0;
         tx_word     <= '0;
         rx_shift    <= '0;
         hold        <= '0;
         hold_full   <= 1'b0;
         tx_empty_o  <= 1'b1;
         rx_data_o   <= '0;
         rx_valid_o  <= 1'b0;
         busy_o      <= 1'b0;
         underrun_o  <= 1'b0;
         frame_err_o <= 1'b0;
         MISO_o      <= 1'b0;
         MISO_oe_o   <= 1'b0;
      end else begin
         rx_valid_o  <= 1'b0;
         underrun_o  <= 1'b0;
         frame_err_o <= 1'b0;

         // A load coinciding with a reload refills the holding register after the old value is taken.
         if (tx_load_i) begin
            hold       <= tx_data_i;
            hold_full  <= 1'b1;
            tx_empty_o <= 1'b0;
         end else if (reload) begin
            hold_full  <= 1'b0;
            tx_empty_o <= 1'b1;
         end

         if (reload) begin
            tx_word    <= reload_word;
            underrun_o <= !hold_full;
         end

         case (state)
            ST_IDLE: begin
               if (cs_fall) begin
                  state     <= ST_ACTIVE;
                  mode_q    <= spi_mode_t'(spi_mode_i);
                  len_q     <= word_len_e'(word_len_i);
                  bit_cnt   <= len_m1;
                  busy_o    <= 1'b1;
                  MISO_oe_o <= 1'b1;
                  if (!mode_eff.cpha) MISO_o <= reload_word[len_m1];
               end
            end
            ST_ACTIVE: begin
               if (cs_rise) begin
                  state     <= ST_IDLE;
                  busy_o    <= 1'b0;
                  MISO_oe_o <= 1'b0;
                  MISO_o    <= 1'b0;
                  if (bit_cnt != len_m1) frame_err_o <= 1'b1;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (sample_hit) begin
            rx_shift <= rx_next;
            if (word_done) begin
               rx_data_o  <= rx_next & len_mask(len_eff);
               rx_valid_o <= 1'b1;
               bit_cnt    <= len_m1;
            end else begin
               bit_cnt <= cnt_eff - 5'd1;
            end
         end

         // Same expression serves both phases: CPHA=1 shifts before the decrement, CPHA=0 after it.
         if (shift_hit) MISO_o <= tx_eff[cnt_eff];
      end
   end

endmodule
